// File: rtl/uart_rx_packer.sv
// 8N1 UART receiver that packs eight consecutive good bytes, first byte in the MSBs,
// into a 64-bit word held in a single-entry output register with valid/read handshake.
module uart_rx_packer #(
    parameter int unsigned SYNC_STAGES = 2
) (
    input  logic        clk100,
    input  logic        rst_n,
    input  logic        RxD,
    input  logic [15:0] ck_div,
    output logic [63:0] msg_dout,
    output logic        msg_valid,
    input  logic        msg_rden,
    output logic        frame_err,
    output logic        overrun
);

    typedef enum logic [1:0] {IDLE, START, DATA, STOP} state_t;

    logic [SYNC_STAGES-1:0] sync_q, sync_d;
    logic                   rx_prev_q;
    logic                   rx_s;
    state_t                 state_q, state_d;
    logic [15:0]            cnt_q, cnt_d;
    logic [15:0]            ck_lat_q, ck_lat_d;
    logic [2:0]             bit_idx_q, bit_idx_d;
    logic [7:0]             shift_q, shift_d;
    logic [2:0]             pack_idx_q, pack_idx_d;
    logic [55:0]            word_q, word_d;
    logic [63:0]            msg_dout_q, msg_dout_d;
    logic                   msg_valid_q, msg_valid_d;
    logic                   frame_err_q, frame_err_d;
    logic                   overrun_q, overrun_d;
    logic                   expired;
    logic                   byte_valid;

    assign rx_s    = sync_q[SYNC_STAGES-1];
    assign sync_d  = {sync_q[SYNC_STAGES-2:0], RxD};
    assign expired = (cnt_q == '0);

    always_comb begin
        state_d     = state_q;
        cnt_d       = cnt_q;
        ck_lat_d    = ck_lat_q;
        bit_idx_d   = bit_idx_q;
        shift_d     = shift_q;
        frame_err_d = 1'b0;
        byte_valid  = 1'b0;

        case (state_q)
            IDLE: begin
                if (rx_prev_q && !rx_s) begin
                    cnt_d    = {1'b0, ck_div[15:1]};
                    ck_lat_d = ck_div;
                    state_d  = START;
                end
            end
            START: begin
                if (expired) begin
                    if (!rx_s) begin
                        state_d   = DATA;
                        cnt_d     = ck_lat_q - 16'd1;
                        bit_idx_d = '0;
                    end else begin
                        state_d = IDLE;
                    end
                end else begin
                    cnt_d = cnt_q - 16'd1;
                end
            end
            DATA: begin
                if (expired) begin
                    shift_d   = {rx_s, shift_q[7:1]};
                    bit_idx_d = bit_idx_q + 3'd1;
                    cnt_d     = ck_lat_q - 16'd1;
                    if (bit_idx_q == 3'd7) begin
                        state_d = STOP;
                    end
                end else begin
                    cnt_d = cnt_q - 16'd1;
                end
            end
            STOP: begin
                if (expired) begin
                    state_d = IDLE;
                    if (rx_s) begin
                        byte_valid = 1'b1;
                    end else begin
                        frame_err_d = 1'b1;
                    end
                end else begin
                    cnt_d = cnt_q - 16'd1;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    // A read and a completing word in the same cycle hand over directly: valid stays high.
    always_comb begin
        pack_idx_d  = pack_idx_q;
        word_d      = word_q;
        msg_dout_d  = msg_dout_q;
        msg_valid_d = msg_valid_q;
        overrun_d   = 1'b0;

        if (msg_valid_q && msg_rden) begin
            msg_valid_d = 1'b0;
        end

        if (byte_valid) begin
            word_d     = {word_q[47:0], shift_q};
            pack_idx_d = pack_idx_q + 3'd1;
            if (pack_idx_q == 3'd7) begin
                if (!msg_valid_q || msg_rden) begin
                    msg_dout_d  = {word_q, shift_q};
                    msg_valid_d = 1'b1;
                end else begin
                    overrun_d = 1'b1;
                end
            end
        end
    end

    always_ff @(posedge clk100) begin
        if (!rst_n) begin
            sync_q      <= '1;
            rx_prev_q   <= 1'b1;
            state_q     <= IDLE;
            cnt_q       <= '0;
            ck_lat_q    <= '0;
            bit_idx_q   <= '0;
            shift_q     <= '0;
            pack_idx_q  <= '0;
            word_q      <= '0;
            msg_dout_q  <= '0;
            msg_valid_q <= 1'b0;
            frame_err_q <= 1'b0;
            overrun_q   <= 1'b0;
        end else begin
            sync_q      <= sync_d;
            rx_prev_q   <= rx_s;
            state_q     <= state_d;
            cnt_q       <= cnt_d;
            ck_lat_q    <= ck_lat_d;
            bit_idx_q   <= bit_idx_d;
            shift_q     <= shift_d;
            pack_idx_q  <= pack_idx_d;
            word_q      <= word_d;
            msg_dout_q  <= msg_dout_d;
            msg_valid_q <= msg_valid_d;
            frame_err_q <= frame_err_d;
            overrun_q   <= overrun_d;
        end
    end

    assign msg_dout  = msg_dout_q;
    assign msg_valid = msg_valid_q;
    assign frame_err = frame_err_q;
    assign overrun   = overrun_q;

endmodule

// File: doc/uart_rx_packer.md
UART_RX_PACKER -- requirements
Module: uart_rx_packer

Interface
REQ-001 Parameter SYNC_STAGES, default 2: number of flip-flops synchronising RxD to clk100 (minimum 2).
REQ-002 Port clk100  input  1  sole clock; all logic SHALL be rising-edge clk100.
REQ-003 Port rst_n  input  1  reset; synchronous and active-low.
REQ-004 Port RxD  input  1  asynchronous UART serial input, 8N1, idle high.
REQ-005 Port ck_div  input  16  clk100 cycles per bit (3472 for 28800 baud); legal range 4..65535.
REQ-006 Port msg_dout  output  64  assembled 8-byte word.
REQ-007 Port msg_valid  output  1  msg_dout holds an unread word.
REQ-008 Port msg_rden  input  1  consumer read strobe; consumes the word when msg_valid=1; ignored when msg_valid=0.
REQ-009 Port frame_err  output  1  one-cycle pulse: stop bit sampled low.
REQ-010 Port overrun  output  1  one-cycle pulse: completed word dropped because the output register was full.

Function
REQ-011 RxD SHALL pass through SYNC_STAGES flops; all sampling SHALL use the synchronised value.
REQ-012 The RX FSM SHALL have the states IDLE, START, DATA and STOP.
REQ-013 IDLE: a synchronised 1->0 transition SHALL load the bit counter with ck_div>>1, latch ck_div internally, and move to START.
REQ-014 START: on counter expiry, a low line SHALL move to DATA with the counter reloaded to latched ck_div-1; a high line SHALL count as a glitch and return to IDLE with no output.
REQ-015 DATA: the line SHALL be sampled at each counter expiry, LSB first, 8 samples, with a 3-bit bit index; after the 8th sample the FSM SHALL move to STOP.
REQ-016 STOP: on expiry, a high line SHALL produce an internal byte-valid strobe on that cycle; a low line SHALL pulse frame_err, discard the byte, and leave the pack index unchanged; both cases SHALL return to IDLE on the next cycle.
REQ-017 A ck_div change mid-frame SHALL take effect only at the next start edge.
REQ-018 Packing SHALL be big-endian: the first byte of a word goes to msg_dout[63:56] and the 8th to [7:0], matching the MSB-first 64b->8b TX FIFO.
REQ-019 A 3-bit pack index SHALL increment per accepted byte and wrap 7->0 when the word completes.
REQ-020 On completion with msg_valid=0, or with msg_valid=1 and msg_rden=1 in the same cycle, the word SHALL load into msg_dout and msg_valid SHALL be 1 on the next edge.
REQ-021 On completion with msg_valid=1 and msg_rden=0, overrun SHALL pulse for one cycle, the word SHALL be dropped, msg_dout/msg_valid SHALL be unchanged, and the pack index SHALL still wrap to 0.
REQ-022 msg_rden with msg_valid=1 and no completion SHALL clear msg_valid on the next edge; msg_dout SHALL hold its value.
REQ-023 Latency: msg_valid SHALL rise on the edge after the 8th byte's stop-bit sample.
REQ-024 A new start edge SHALL be accepted in the first IDLE cycle after STOP, supporting back-to-back frames.

Reset
REQ-025 rst_n=0 at a clock edge SHALL force: FSM=IDLE, counters and pack index=0, msg_dout=0, msg_valid=0, frame_err=0, overrun=0, and sync flops=1 (idle).
REQ-026 Reset mid-frame or mid-word SHALL discard all partial data; the first start edge after release SHALL begin byte 0 of a new word.

Verification (ck_div=16)
REQ-027 Send 0x01..0x08 -> msg_dout=64'h0102030405060708, msg_valid=1 one cycle after the last stop sample.
REQ-028 Send byte 0x55 with stop bit low -> frame_err pulses exactly once; the next 8 good bytes 0xA0..0xA7 yield 64'hA0A1A2A3A4A5A6A7.
REQ-029 Hold RxD low for 4 cycles in IDLE -> no byte accepted, no frame_err, FSM back in IDLE.
REQ-030 Two full words with msg_rden held 0 -> first word retained, overrun pulses once; repeat with msg_rden=1 on the completion cycle -> second word loaded, msg_valid stays 1.
REQ-031 Assert rst_n=0 after 3 bytes and during a DATA bit, then send 8 bytes 0x11..0x88 -> msg_dout=64'h1122334455667788.
REQ-032 Back-to-back frames with zero idle between stop and next start -> all 8 bytes received correctly.
